// File: rtl/seg_pkg.sv
// Shared definitions for the six-digit multiplexed 7-segment display driver.
package seg_pkg;

  // Number of digits on the display; the 3-bit select covers indices 0..5.
  localparam int NDIG = 6;

  // Active-low "everything dark" patterns for segments and digit enables.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [5:0] AN_OFF  = 6'b111111;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by code.
  // Code 14 shows 'E' (selector disabled), code 15 shows '-' (illegal index).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111111,  // 15 '-'
    7'b0000110,  // 14 'E'
    7'b0100001,  // 13 d
    7'b1000110,  // 12 C
    7'b0000011,  // 11 b
    7'b0001000,  // 10 A
    7'b0010000,  //  9
    7'b0000000,  //  8
    7'b1111000,  //  7
    7'b0000010,  //  6
    7'b0010010,  //  5
    7'b0011001,  //  4
    7'b0110000,  //  3
    7'b0100100,  //  2
    7'b1111001,  //  1
    7'b1000000   //  0
  };

  // Scan states: a blanking interval at the start of each slot, then the digit is lit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Pure combinational lookup from a 4-bit digit code to active-low segments.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit time-multiplexed 7-segment scan controller. Each digit slot lasts
// DIV cycles; the first BLANK cycles keep all digits dark so the selector
// output and the registered segments settle before the digit is enabled.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] code,
  output logic [2:0] sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int             CW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);
  localparam logic [2:0]     SEL_LAST   = 3'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_e   state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_dec;
  logic          tick_q, tick_d;
  logic          slot_end;

  seg7_decode u_decode (
    .code_i (code),
    .seg_o  (seg_dec)
  );

  assign slot_end = (cnt_q == CNT_LAST);

  // Next-state logic: slot counter, blank/show phase, digit advance and frame pulse.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    an_d    = AN_OFF;
    if (!en) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
    end else begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        ST_SHOW:  if (slot_end)            state_d = ST_BLANK;
        default:                           state_d = ST_BLANK;
      endcase
      if (slot_end) begin
        sel_d  = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        tick_d = (sel_q == SEL_LAST);
      end
    end
    if (state_d == ST_SHOW) begin
      an_d = ~(6'b000001 << sel_d);
    end
  end

  // State and output registers; segments re-register the decoded code every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_BLANK;
      sel_q   <= 3'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_dec;
      tick_q  <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a small slot-timing reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] code = 4'd0;
  logic [2:0] sel;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frameTick;

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Segment patterns {g..a}, active-low, for codes 0..15.
  logic [6:0] segRef [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0111111
  };

  // Reference model: position within slot, current digit, last segment value, frame pulse.
  int         mPos = 0;
  int         mSel = 0;
  logic [6:0] mSeg = 7'h7f;
  logic       mTick = 1'b0;
  logic [3:0] digits [6];

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .code       (code),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frameTick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rnd4();
    logic [31:0] r;
    r = $urandom;
    return r[3:0];
  endfunction

  // Drive one cycle of inputs and predict what the outputs hold after the next edge.
  task automatic applyStimulus(input logic r, input logic e, input logic useSelector,
                               input logic [3:0] rawCode);
    exp_t       x;
    logic [2:0] s;
    @(negedge clk);
    rst  = r;
    en   = e;
    code = useSelector ? digits[mSel] : rawCode;
    if (r) begin
      mPos = 0; mSel = 0; mTick = 1'b0; mSeg = 7'b1111111;
    end else begin
      mSeg = segRef[code];
      if (!e) begin
        mPos = 0; mTick = 1'b0;
      end else if (mPos == DIV - 1) begin
        mPos = 0; mTick = (mSel == 5); mSel = (mSel + 1) % 6;
      end else begin
        mPos = mPos + 1; mTick = 1'b0;
      end
    end
    s      = mSel[2:0];
    x.sel  = s;
    x.an   = (!r && mPos >= BLANK) ? ~(6'b000001 << s) : 6'b111111;
    x.seg  = mSeg;
    x.dp   = 1'b1;
    x.tick = mTick;
    expQ.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    vectors += 5;
    if (sel !== x.sel) begin
      miscompares++;
      $display("[TB] FAIL sel: got %0d expected %0d at %0t", sel, x.sel, $time);
    end
    if (an !== x.an) begin
      miscompares++;
      $display("[TB] FAIL an: got %b expected %b at %0t", an, x.an, $time);
    end
    if (seg !== x.seg) begin
      miscompares++;
      $display("[TB] FAIL seg: got %b expected %b at %0t", seg, x.seg, $time);
    end
    if (dp !== x.dp) begin
      miscompares++;
      $display("[TB] FAIL dp: got %b expected %b at %0t", dp, x.dp, $time);
    end
    if (frameTick !== x.tick) begin
      miscompares++;
      $display("[TB] FAIL frame_tick: got %b expected %b at %0t", frameTick, x.tick, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output word; compare it against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Run with en=1 until the model reaches the given digit and slot position, bounded.
  task automatic runUntil(input int wantSel, input int wantPos, input string what);
    int n;
    n = 0;
    while (!(mSel == wantSel && mPos == wantPos) && n < 200) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
      n++;
    end
    if (n >= 200) begin
      miscompares++;
      $display("[TB] FAIL %s: position not reached, got sel %0d pos %0d expected sel %0d pos %0d",
               what, mSel, mPos, wantSel, wantPos);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) digits[i] = rnd4();

    // Reset held for three cycles with arbitrary en and code.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd4() > 4'd7, 1'b0, rnd4());

    // Known digits 1,6,0,7 on sel 0..3, two full frames of scanning.
    digits[0] = 4'd1; digits[1] = 4'd6; digits[2] = 4'd0; digits[3] = 4'd7;
    for (int i = 0; i < 2 * 6 * DIV; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);

    // Sweep codes 2..13 through the selector path.
    for (int c = 2; c <= 13; c += 6) begin
      for (int d = 0; d < 6; d++) digits[d] = 4'(c + d);
      for (int i = 0; i < 6 * DIV; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    end

    // Raw codes straight into the segment path, including the two error codes.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd14);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd14);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b0, rnd4());

    // Drop en at position 5 of the sel=2 slot, then resume.
    for (int d = 0; d < 6; d++) digits[d] = rnd4();
    runUntil(2, 5, "en_drop_reach");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < DIV + 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);

    // Reset during the lit phase of digit 3.
    runUntil(3, BLANK + 1, "mid_reset_reach");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 2 * DIV; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);

    // Randomized operation with occasional en drops, resets and raw codes.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r[31:26] == 6'd0) for (int d = 0; d < 6; d++) digits[d] = rnd4();
      applyStimulus(r[7:0] == 8'd0, r[11:8] != 4'd0, r[15:12] != 4'd0, r[19:16]);
    end

    @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed six-digit 7-segment display driver. It sits directly downstream of the 4-bit 6-to-1 digit selector. It generates the selector's 3-bit sel, registers and decodes the returned 4-bit digit code into active-low segments, and drives the active-low digit enables. Each digit slot starts with a blanking interval to suppress ghosting while the selector output and segments settle.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range 2 and above.
BLANK, 1000, blanked cycles at the start of each slot; legal range 1 to DIV-1.
NDIG, 6, number of digits; fixed at 6 and must match the 3-bit sel range.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
en  input  1  scan enable, active-high.
code  input  4  digit code returned by the selector for the current sel (combinational path).
sel  output  3  digit index to the selector, 0..5.
an  output  6  digit enables, active-low; an[i] drives digit i.
seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
dp  output  1  decimal point, active-low; held at 1 (off).
frame_tick  output  1  one-cycle pulse when sel wraps from 5 to 0.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values, applied on the first edge with rst=1:
  - sel=0, an=6'b111111, seg=7'b1111111, dp=1, frame_tick=0.
  - Slot counter=0, state=BLANK.
- Slot counter:
  - Width $clog2(DIV).
  - Counts 0..DIV-1 while en=1, then wraps to 0.
- State machine, two states:
  - BLANK: an=6'b111111. Move to SHOW when counter==BLANK-1.
  - SHOW: an has only bit sel low. Move to BLANK when counter==DIV-1.
- Slot end (counter==DIV-1):
  - sel advances on the same edge: sel+1, with 5 wrapping to 0.
  - sel never takes values 6 or 7.
  - frame_tick=1 for exactly the one cycle after the edge where sel goes from 5 to 0; otherwise 0.
- Segment path:
  - seg is registered from code every cycle, giving 1-cycle latency from a code change to seg.
  - BLANK >= 1 guarantees seg is valid before an asserts.
- Decode table (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001
  - 14=0000110 ('E', selector disabled)
  - 15=0111111 ('-', selector illegal index)
- en=0:
  - Next edge: state=BLANK, counter=0, an=6'b111111, frame_tick=0.
  - sel holds; seg keeps tracking code.
  - When en returns to 1, the slot restarts on the held sel with a full BLANK interval.
- Simultaneous events:
  - rst has priority over en.
  - en=0 has priority over slot end; sel does not advance.
- Reset mid-slot: the next edge applies all reset values regardless of state.

Decomposition:
- Shared package seg_pkg holds:
  - NDIG.
  - The 16-entry active-low segment constant table.
  - SEG_OFF=7'b1111111 and AN_OFF=6'b111111.
  - The state enum {BLANK, SHOW}.
- One sub-module is natural: seg7_decode, a pure combinational 4-bit-to-7-bit lookup driven by seg_pkg.
- seg_scan_ctrl instantiates seg7_decode and registers its output.

Test Plan:
- Reset: rst=1 for 3 cycles, any en or code -> sel=0, an=111111, seg=1111111, dp=1, frame_tick=0 from the first edge.
- Scan order (DIV=8, BLANK=2, en=1):
  - sel steps 0,1,2,3,4,5,0, changing every 8 cycles.
  - Per slot: an=111111 for 2 cycles, then 6 cycles of an = 111110, 111101, 111011, 110111, 101111, 011111 for sel 0..5.
  - frame_tick pulses once every 48 cycles.
- Decode via a selector model (sel 0..3 -> codes 1,6,0,7): during SHOW, seg = 1111001, 0000010, 1000000, 1111000 respectively. Sweep codes 2..13 against the table.
- Error codes: code=14 -> seg=0000110; code=15 -> seg=0111111, both one cycle after code is applied.
- en drop at counter=5 of the sel=2 slot:
  - Next cycle an=111111 and sel stays 2.
  - After en rises again: 2 blank cycles, then an=111011 for 6 cycles, then sel=3.
- Reset mid-operation during SHOW at sel=3 -> next edge sel=0, an=111111, seg=1111111, state BLANK, no frame_tick pulse.
